// File: rtl/tinyodin_tick_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tinyodin_sched_pkg
// Shared definitions for the tinyODIN tick scheduler slice.
//   - sched_state_e : scheduler FSM states (IDLE..FINISH)
//   - ST_*          : plain logic constants holding the same encodings, for
//                     code that keeps the state in a logic vector
//   - DEFAULT_*     : default parameter values for the scheduler
// ---------------------------------------------------------------------------
package tinyodin_sched_pkg;

  localparam int DEFAULT_INPUT_RESO  = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    FINISH  = 3'd4
  } sched_state_e;

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_ISSUE   = ISSUE;
  localparam logic [2:0] ST_WAIT    = WAIT;
  localparam logic [2:0] ST_ADVANCE = ADVANCE;
  localparam logic [2:0] ST_FINISH  = FINISH;

endpackage

// File: rtl/tinyodin_tick_scheduler_done_joiner.sv
// ---------------------------------------------------------------------------
// tinyodin_done_joiner
// Remembers which of two done pulses have arrived and reports when both have.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   clr       : clear both sticky flags (has priority over capture)
//   en        : capture window; pulses outside it are ignored
//   done_a/b  : 1-cycle done pulses, any order, possibly the same cycle
//   joined    : both dones seen, counting a pulse present this very cycle
// ---------------------------------------------------------------------------
module tinyodin_done_joiner
  import tinyodin_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  input  logic done_a,
  input  logic done_b,
  output logic joined
);

  logic flag_a;
  logic flag_b;
  logic hit_a;
  logic hit_b;

  assign hit_a = en & done_a;
  assign hit_b = en & done_b;

  // Sticky flags: repeated pulses simply re-set an already set flag.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      flag_a <= 1'b0;
      flag_b <= 1'b0;
    end else begin
      flag_a <= flag_a | hit_a;
      flag_b <= flag_b | hit_b;
    end
  end

  // Looking at the live pulse as well saves a cycle when the second done arrives.
  assign joined = (flag_a | hit_a) & (flag_b | hit_b);

endmodule

// File: rtl/tinyodin_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tinyodin_tick_scheduler
// Sequences tinyODIN time steps: for each tick it pulses a start to the spike
// core and the ODIN core, waits for both done pulses, then counts the tick
// index down until the run ends. A watchdog abandons a tick whose done pulses
// never arrive and raises a sticky timeout flag.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   start_i, num_ticks_i: run request and run length (0 = empty run)
//   abort_i             : abandon the current run, beats every other event
//   spikecore_done_i,
//   ODIN_done_i         : per-tick completion pulses from the two cores
//   spikecore_start_o,
//   odin_start_o        : per-tick start pulses to the two cores
//   tick_o              : current tick index (valid while busy_o)
//   next_tick_o         : both cores finished tick_o
//   busy_o              : run in progress
//   run_done_o          : run finished normally
//   timeout_o           : sticky watchdog error, cleared by a new run
// ---------------------------------------------------------------------------
module tinyodin_tick_scheduler
  import tinyodin_sched_pkg::*;
#(
  parameter int INPUT_RESO  = DEFAULT_INPUT_RESO,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [INPUT_RESO-1:0] num_ticks_i,
  input  logic                  spikecore_done_i,
  input  logic                  ODIN_done_i,
  output logic                  spikecore_start_o,
  output logic                  odin_start_o,
  output logic [INPUT_RESO-1:0] tick_o,
  output logic                  next_tick_o,
  output logic                  busy_o,
  output logic                  run_done_o,
  output logic                  timeout_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [INPUT_RESO-1:0] tick;
  logic [TO_W-1:0]       wd_cnt;
  logic                  timeout_q;
  logic                  both_done;
  logic                  wd_expired;
  logic                  accept_start;

  // Flags only listen in WAIT, so done pulses seen during ISSUE are dropped.
  tinyodin_done_joiner u_joiner (
    .CLK    (CLK),
    .RST    (RST),
    .clr    ((state != ST_WAIT) | abort_i),
    .en     (state == ST_WAIT),
    .done_a (spikecore_done_i),
    .done_b (ODIN_done_i),
    .joined (both_done)
  );

  // The current WAIT cycle is the last one the watchdog allows.
  assign wd_expired   = (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign accept_start = (state == ST_IDLE) & start_i & ~abort_i;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept_start) state_nxt = (num_ticks_i == '0) ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (both_done)       state_nxt = ST_ADVANCE;
        else if (wd_expired) state_nxt = ST_IDLE;
      end
      ST_ADVANCE: state_nxt = (tick == '0) ? ST_FINISH : ST_ISSUE;
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (abort_i) state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      tick      <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept_start) begin
        timeout_q <= 1'b0;
        tick      <= (num_ticks_i == '0) ? '0 : num_ticks_i - 1'b1;
      end

      if (state == ST_ISSUE) wd_cnt <= '0;
      else if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;

      // A done pulse in the final watchdog cycle still rescues the tick.
      if (state == ST_WAIT && !abort_i && !both_done && wd_expired) timeout_q <= 1'b1;

      // The index only moves on ADVANCE, and never below zero.
      if (state == ST_ADVANCE && !abort_i && tick != '0) tick <= tick - 1'b1;
    end
  end

  assign spikecore_start_o = (state == ST_ISSUE);
  assign odin_start_o      = (state == ST_ISSUE);
  assign next_tick_o       = (state == ST_ADVANCE);
  assign run_done_o        = (state == ST_FINISH);
  assign busy_o            = (state != ST_IDLE);
  assign tick_o            = tick;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_tinyodin_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tinyodin_tick_scheduler
// Drives directed runs into the tick scheduler and compares every output on
// every falling edge against a run-level reference model, alongside literal
// expectations worked out by hand for each scenario.
// ---------------------------------------------------------------------------
module tb_tinyodin_tick_scheduler;

  localparam int RESO = 8;
  localparam int TO   = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [RESO-1:0] num_ticks_i = '0;
  logic            spikecore_done_i = 1'b0;
  logic            ODIN_done_i = 1'b0;
  logic            spikecore_start_o;
  logic            odin_start_o;
  logic [RESO-1:0] tick_o;
  logic            next_tick_o;
  logic            busy_o;
  logic            run_done_o;
  logic            timeout_o;

  int testsRun  = 0;
  int testsFail = 0;

  tinyodin_tick_scheduler #(.INPUT_RESO(RESO), .TIMEOUT_CYC(TO)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .start_i           (start_i),
    .abort_i           (abort_i),
    .num_ticks_i       (num_ticks_i),
    .spikecore_done_i  (spikecore_done_i),
    .ODIN_done_i       (ODIN_done_i),
    .spikecore_start_o (spikecore_start_o),
    .odin_start_o      (odin_start_o),
    .tick_o            (tick_o),
    .next_tick_o       (next_tick_o),
    .busy_o            (busy_o),
    .run_done_o        (run_done_o),
    .timeout_o         (timeout_o)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the run as "ticks still to do" plus which pulse
  // the scheduler owes the outside world next; updated from the inputs seen
  // at each rising edge.
  bit m_valid = 0;
  bit m_busy, m_start, m_next, m_done, m_timeout, m_waiting, m_got_s, m_got_o;
  int m_tick, m_wait_cnt;

  always @(posedge CLK) begin
    if (RST) begin
      m_valid = 1;
      m_busy = 0; m_start = 0; m_next = 0; m_done = 0;
      m_timeout = 0; m_waiting = 0; m_tick = 0;
    end else if (m_busy && abort_i) begin
      m_busy = 0; m_start = 0; m_next = 0; m_done = 0; m_waiting = 0;
    end else if (!m_busy) begin
      if (start_i && !abort_i) begin
        m_timeout = 0;
        m_busy = 1;
        if (num_ticks_i == 0) begin
          m_tick = 0;
          m_done = 1;
        end else begin
          m_tick = int'(num_ticks_i) - 1;
          m_start = 1;
        end
      end
    end else if (m_start) begin
      m_start = 0; m_waiting = 1; m_got_s = 0; m_got_o = 0; m_wait_cnt = 0;
    end else if (m_waiting) begin
      m_got_s = m_got_s | spikecore_done_i;
      m_got_o = m_got_o | ODIN_done_i;
      m_wait_cnt++;
      if (m_got_s && m_got_o) begin
        m_waiting = 0; m_next = 1;
      end else if (m_wait_cnt == TO) begin
        m_waiting = 0; m_busy = 0; m_timeout = 1;
      end
    end else if (m_next) begin
      m_next = 0;
      if (m_tick == 0) m_done = 1;
      else begin
        m_tick = m_tick - 1;
        m_start = 1;
      end
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      checkOutput("spikecore_start_o", int'(spikecore_start_o), int'(m_start));
      checkOutput("odin_start_o", int'(odin_start_o), int'(m_start));
      checkOutput("next_tick_o", int'(next_tick_o), int'(m_next));
      checkOutput("run_done_o", int'(run_done_o), int'(m_done));
      checkOutput("busy_o", int'(busy_o), int'(m_busy));
      checkOutput("timeout_o", int'(timeout_o), int'(m_timeout));
      if (m_busy) checkOutput("tick_o", int'(tick_o), m_tick);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input int num);
    start_i = 1'b1;
    num_ticks_i = RESO'(num);
    step(1);
    start_i = 1'b0;
  endtask

  task automatic pulseDone(input logic s, input logic o);
    spikecore_done_i = s;
    ODIN_done_i = o;
    step(1);
    spikecore_done_i = 1'b0;
    ODIN_done_i = 1'b0;
  endtask

  task automatic waitStart(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (spikecore_start_o) begin
        seen = 1;
        break;
      end
      step(1);
    end
    checkOutput(name, int'(seen), 1);
  endtask

  initial begin
    step(2);
    RST = 1'b0;
    checkOutput("reset busy_o", int'(busy_o), 0);
    checkOutput("reset tick_o", int'(tick_o), 0);
    checkOutput("reset timeout_o", int'(timeout_o), 0);
    step(2);

    // T1: three ticks, both dones together 5 cycles after each start
    applyStimulus(3);
    checkOutput("T1 start latency", int'(spikecore_start_o), 1);
    for (int k = 0; k < 3; k++) begin
      waitStart("T1 start seen");
      checkOutput("T1 tick at start", int'(tick_o), 2 - k);
      step(5);
      pulseDone(1'b1, 1'b1);
      checkOutput("T1 next_tick", int'(next_tick_o), 1);
      checkOutput("T1 tick at advance", int'(tick_o), 2 - k);
      step(1);
      if (k < 2) checkOutput("T1 restart latency", int'(odin_start_o), 1);
    end
    checkOutput("T1 run_done", int'(run_done_o), 1);
    step(1);
    checkOutput("T1 busy falls", int'(busy_o), 0);
    step(2);

    // T2: ODIN done arrives 4 cycles ahead of spike done
    applyStimulus(2);
    for (int k = 0; k < 2; k++) begin
      waitStart("T2 start seen");
      step(2);
      pulseDone(1'b0, 1'b1);
      checkOutput("T2 no early advance", int'(next_tick_o), 0);
      step(3);
      pulseDone(1'b1, 1'b0);
      checkOutput("T2 next_tick", int'(next_tick_o), 1);
      checkOutput("T2 tick", int'(tick_o), 1 - k);
    end
    step(1);
    checkOutput("T2 run_done", int'(run_done_o), 1);
    step(3);

    // T3: empty run
    applyStimulus(0);
    checkOutput("T3 run_done", int'(run_done_o), 1);
    checkOutput("T3 busy", int'(busy_o), 1);
    checkOutput("T3 no start", int'(spikecore_start_o), 0);
    step(1);
    checkOutput("T3 busy falls", int'(busy_o), 0);
    step(2);

    // T4: watchdog, only the spike core answers
    applyStimulus(2);
    waitStart("T4 start seen");
    step(1);
    pulseDone(1'b1, 1'b0);
    step(14);
    checkOutput("T4 busy before expiry", int'(busy_o), 1);
    checkOutput("T4 timeout before expiry", int'(timeout_o), 0);
    step(1);
    checkOutput("T4 timeout", int'(timeout_o), 1);
    checkOutput("T4 idle", int'(busy_o), 0);
    checkOutput("T4 no run_done", int'(run_done_o), 0);
    step(3);
    checkOutput("T4 timeout sticky", int'(timeout_o), 1);
    applyStimulus(1);
    checkOutput("T4 timeout cleared", int'(timeout_o), 0);
    waitStart("T4 rerun start");
    step(2);
    pulseDone(1'b1, 1'b1);
    step(3);

    // T5: abort during the wait of tick 5, then a clean one-tick run
    applyStimulus(8);
    for (int k = 0; k < 2; k++) begin
      waitStart("T5 start seen");
      step(3);
      pulseDone(1'b1, 1'b1);
    end
    waitStart("T5 tick5 start");
    checkOutput("T5 tick5", int'(tick_o), 5);
    step(3);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    checkOutput("T5 aborted idle", int'(busy_o), 0);
    checkOutput("T5 no run_done", int'(run_done_o), 0);
    pulseDone(1'b1, 1'b1);
    step(1);
    checkOutput("T5 late dones ignored", int'(next_tick_o), 0);
    applyStimulus(1);
    waitStart("T5 restart start");
    step(2);
    pulseDone(1'b1, 1'b1);
    checkOutput("T5 restart next_tick", int'(next_tick_o), 1);
    step(1);
    checkOutput("T5 restart run_done", int'(run_done_o), 1);
    step(2);

    // T6: start ignored mid-run, then reset mid-WAIT
    applyStimulus(4);
    waitStart("T6 start seen");
    start_i = 1'b1;
    num_ticks_i = RESO'(9);
    step(1);
    start_i = 1'b0;
    step(2);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    checkOutput("T6 tick unchanged", int'(tick_o), 3);
    checkOutput("T6 still busy", int'(busy_o), 1);
    RST = 1'b1;
    step(1);
    checkOutput("T6 reset busy", int'(busy_o), 0);
    checkOutput("T6 reset tick", int'(tick_o), 0);
    checkOutput("T6 reset start", int'(spikecore_start_o), 0);
    RST = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not complete");
    $fatal(1, "[TB] stuck");
  end

endmodule
